// File: rtl/my_if_rx_buffer.sv
// Receive side of the my_if valid/ready link: buffers producer beats in a small
// first-word-fall-through FIFO and tracks sticky receive/protocol status.
module my_if_rx_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [15:0]                  beat_cnt,
    output logic                         rx_status,
    output logic                         proto_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [15:0] BEAT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    logic             rx_status_q, rx_status_d;
    logic             proto_err_q, proto_err_d;
    logic             stalled_q, stalled_d;
    logic [WIDTH-1:0] stall_data_q, stall_data_d;

    logic push;
    logic pop;
    logic violation;

    // Ready depends only on state, reset and flush, never on the producer's valid.
    assign in_ready  = !rst && !flush && (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign beat_cnt  = beat_cnt_q;
    assign rx_status = rx_status_q;
    assign proto_err = proto_err_q;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    // A stalled beat must stay valid with unchanged data until accepted.
    assign violation = stalled_q && (!in_valid || (in_data != stall_data_q));

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        beat_cnt_d   = beat_cnt_q;
        rx_status_d  = rx_status_q;
        proto_err_d  = proto_err_q;
        stalled_d    = in_valid && !in_ready;
        stall_data_d = in_data;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            beat_cnt_d  = '0;
            rx_status_d = 1'b0;
            proto_err_d = 1'b0;
            stalled_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
                rx_status_d     = 1'b1;
                if (beat_cnt_q != BEAT_MAX) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (violation) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            beat_cnt_q   <= '0;
            rx_status_q  <= 1'b0;
            proto_err_q  <= 1'b0;
            stalled_q    <= 1'b0;
            stall_data_q <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            beat_cnt_q   <= beat_cnt_d;
            rx_status_q  <= rx_status_d;
            proto_err_q  <= proto_err_d;
            stalled_q    <= stalled_d;
            stall_data_q <= stall_data_d;
        end
    end

endmodule

// File: tb/tb_my_if_rx_buffer.sv
// Scoreboard bench for my_if_rx_buffer: beats are queued when accepted and
// compared when the FIFO hands them downstream.
module tb_my_if_rx_buffer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;
    logic [15:0] beat_cnt;
    logic        rx_status;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    my_if_rx_buffer #(.DEPTH(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count),
        .beat_cnt  (beat_cnt),
        .rx_status (rx_status),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; report which handshakes fire at the coming edge.
    task automatic step(output logic did_push, output logic did_pop, output logic [7:0] pop_data);
        @(negedge clk);
        did_push = in_valid && in_ready;
        did_pop  = out_valid && out_ready;
        pop_data = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        logic p, po;
        logic [7:0] pd;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        step(p, po, pd);
        flush = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during_rst got=%b exp=0", in_ready); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (beat_cnt !== 16'd0) begin failures++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
        checks++; if (rx_status !== 1'b0) begin failures++; $display("FAIL reset_rx_status got=%b exp=0", rx_status); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    endtask

    task automatic test_fill();
        logic p, po;
        logic [7:0] pd, exp;
        logic [7:0] vals [5];
        int pops;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            step(p, po, pd);
            if (p) sb.push_back(vals[i]);
        end
        in_data = vals[4];
        step(p, po, pd);
        if (p) sb.push_back(vals[4]);
        step(p, po, pd);
        if (p) sb.push_back(vals[4]);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count_full got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready_full got=%b exp=0", in_ready); end
        checks++; if (rx_status !== 1'b1) begin failures++; $display("FAIL fill_rx_status got=%b exp=1", rx_status); end
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 20 && pops < 5; c++) begin
            step(p, po, pd);
            if (p) begin sb.push_back(vals[4]); in_valid = 1'b0; end
            if (po) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL fill_unexpected_pop got=%h exp=none", pd);
                end else begin
                    exp = sb.pop_front();
                    if (pd !== exp) begin failures++; $display("FAIL fill_pop_data got=%h exp=%h", pd, exp); end
                end
                pops++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (pops != 5) begin failures++; $display("FAIL fill_drain_timeout got=%0d exp=5 pops", pops); end
        checks++; if (beat_cnt !== 16'd5) begin failures++; $display("FAIL fill_beat_cnt got=%0d exp=5", beat_cnt); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL fill_proto_err got=%b exp=0", proto_err); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fill_count_empty got=%0d exp=0", count); end
    endtask

    task automatic test_streaming();
        logic p, po;
        logic [7:0] pd, exp, cur;
        int pops, bad_data, bad_count;
        do_flush();
        pops = 0; bad_data = 0; bad_count = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cur = 8'(i * 3 + 1);
            in_data = cur;
            step(p, po, pd);
            if (p) sb.push_back(cur);
            if (po) begin
                pops++;
                if (sb.size() == 0) bad_data++;
                else begin exp = sb.pop_front(); if (pd !== exp) bad_data++; end
            end
            if (count !== 3'd1) bad_count++;
        end
        in_valid = 1'b0;
        step(p, po, pd);
        if (po) begin
            pops++;
            if (sb.size() == 0) bad_data++;
            else begin exp = sb.pop_front(); if (pd !== exp) bad_data++; end
        end
        out_ready = 1'b0;
        checks++; if (bad_data != 0) begin failures++; $display("FAIL stream_data got=%0d exp=0 bad beats", bad_data); end
        checks++; if (bad_count != 0) begin failures++; $display("FAIL stream_count got=%0d exp=0 cycles with count!=1", bad_count); end
        checks++; if (pops != 100) begin failures++; $display("FAIL stream_pops got=%0d exp=100", pops); end
        checks++; if (beat_cnt !== 16'd100) begin failures++; $display("FAIL stream_beat_cnt got=%0d exp=100", beat_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_out_valid_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_proto();
        logic p, po;
        logic [7:0] pd;
        do_flush();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step(p, po, pd);
        end
        in_data = 8'hA5;
        step(p, po, pd);
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_early got=%b exp=0", proto_err); end
        in_data = 8'h5A;
        step(p, po, pd);
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_set got=%b exp=1", proto_err); end
        in_valid = 1'b0;
        step(p, po, pd);
        step(p, po, pd);
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_sticky got=%b exp=1", proto_err); end
        do_flush();
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_flush_err got=%b exp=0", proto_err); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL proto_flush_count got=%0d exp=0", count); end
        checks++; if (rx_status !== 1'b0) begin failures++; $display("FAIL proto_flush_rx_status got=%b exp=0", rx_status); end
    endtask

    task automatic test_flush_concurrent();
        logic p, po;
        logic [7:0] pd;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + i);
            step(p, po, pd);
        end
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL flushc_pre_count got=%0d exp=2", count); end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flushc_in_ready_during got=%b exp=0", in_ready); end
        step(p, po, pd);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flushc_count got=%0d exp=0", count); end
        checks++; if (beat_cnt !== 16'd0) begin failures++; $display("FAIL flushc_beat_cnt got=%0d exp=0", beat_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flushc_in_ready_after got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flushc_out_valid got=%b exp=0", out_valid); end
        sb.delete();
    endtask

    task automatic test_async_reset();
        logic p, po;
        logic [7:0] pd;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h70 + i);
            step(p, po, pd);
        end
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL arst_pre_count got=%0d exp=3", count); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_release_in_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_streaming();
        test_proto();
        test_flush_concurrent();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
